// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator request panel:
//   - default floor count and floor-index width
//   - encoding of the last travel direction seen from the controller
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 4;
    localparam int FLOOR_W_DEF    = 2;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/elevator_request_panel_request_latch.sv
// -----------------------------------------------------------------------------
// request_latch
// Holds one class of requests (car, hall-up or hall-down), one bit per floor.
// A new press on a non-pending bit latches it and emits a one-cycle pulse.
// A clear drops the bit at the same edge and suppresses any press on it.
// The resend strobe re-pulses every bit that is still pending.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   press    in   [NUM_FLOORS] press events (already edge-detected)
//   clear    in   [NUM_FLOORS] service clears for this cycle
//   resend   in   re-pulse all pending bits
//   pending  out  [NUM_FLOORS] held request state (lamps)
//   pulse    out  [NUM_FLOORS] one-cycle request pulses
// -----------------------------------------------------------------------------
module request_latch #(
    parameter int NUM_FLOORS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] press,
    input  logic [NUM_FLOORS-1:0] clear,
    input  logic                  resend,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] pulse
);

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] pulse_q,   pulse_d;
    logic [NUM_FLOORS-1:0] new_bits;

    always_comb begin
        // Service wins over a press on the same bit in the same cycle.
        new_bits  = press & ~pending_q & ~clear;
        pending_d = (pending_q | press) & ~clear;
        pulse_d   = new_bits;
        if (resend) begin
            pulse_d = new_bits | (pending_q & ~clear);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            pulse_q   <= '0;
        end else begin
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pending = pending_q;
    assign pulse   = pulse_q;

endmodule

// File: rtl/elevator_request_panel.sv
// -----------------------------------------------------------------------------
// elevator_request_panel
// Front-end for elevator_controller. Turns raw button levels into latched
// requests, one-cycle request pulses and lamp states; clears requests as the
// controller serves floors; periodically re-issues unserved requests and
// flags a stall after repeated unanswered re-issues.
//
// Ports:
//   clk             in   system clock (rising edge)
//   reset           in   synchronous active-high reset
//   btn_car         in   [NUM_FLOORS] in-car buttons (level)
//   btn_up          in   [NUM_FLOORS] hall up buttons, top bit ignored
//   btn_down        in   [NUM_FLOORS] hall down buttons, bit 0 ignored
//   current_floor   in   [FLOOR_W] floor reported by the controller
//   moving_up       in   controller travelling up
//   moving_down     in   controller travelling down
//   door_open       in   controller door open
//   inside_request  out  [NUM_FLOORS] car request pulses
//   call_up         out  [NUM_FLOORS] hall up pulses
//   call_down       out  [NUM_FLOORS] hall down pulses
//   lamp_car        out  [NUM_FLOORS] pending car requests
//   lamp_up         out  [NUM_FLOORS] pending up calls
//   lamp_down       out  [NUM_FLOORS] pending down calls
//   stuck           out  service stall flag
// -----------------------------------------------------------------------------
module elevator_request_panel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int FLOOR_W       = FLOOR_W_DEF,
    parameter int RESEND_CYCLES = 64,
    parameter int MAX_RESEND    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_car,
    input  logic [NUM_FLOORS-1:0] btn_up,
    input  logic [NUM_FLOORS-1:0] btn_down,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  moving_up,
    input  logic                  moving_down,
    input  logic                  door_open,
    output logic [NUM_FLOORS-1:0] inside_request,
    output logic [NUM_FLOORS-1:0] call_up,
    output logic [NUM_FLOORS-1:0] call_down,
    output logic [NUM_FLOORS-1:0] lamp_car,
    output logic [NUM_FLOORS-1:0] lamp_up,
    output logic [NUM_FLOORS-1:0] lamp_down,
    output logic                  stuck
);

    localparam logic [NUM_FLOORS-1:0] BOT_BIT = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [NUM_FLOORS-1:0] TOP_BIT = {1'b1, {(NUM_FLOORS-1){1'b0}}};

    localparam int TIMER_W = (RESEND_CYCLES > 2) ? $clog2(RESEND_CYCLES) : 1;
    localparam int CNT_W   = (MAX_RESEND > 0) ? $clog2(MAX_RESEND + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESEND_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_RESEND);

    // Button history, edge detect
    logic [NUM_FLOORS-1:0] car_btn_q,  up_btn_q,  down_btn_q;
    logic [NUM_FLOORS-1:0] up_lvl,     down_lvl;
    logic [NUM_FLOORS-1:0] press_car,  press_up,  press_down;

    // Service decode
    logic [NUM_FLOORS-1:0] serve;
    logic [NUM_FLOORS-1:0] clr_car,    clr_up,    clr_down;
    logic                  any_pending;
    logic                  any_clear;

    // Direction, resend timer, resend counter
    dir_e                  last_dir_q, last_dir_d;
    logic [TIMER_W-1:0]    timer_q,    timer_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  resend;

    // Invalid hall buttons are masked before edge detection so they never
    // produce a press, regardless of what the wiring drives on them.
    assign up_lvl   = btn_up   & ~TOP_BIT;
    assign down_lvl = btn_down & ~BOT_BIT;

    assign press_car  = btn_car  & ~car_btn_q;
    assign press_up   = up_lvl   & ~up_btn_q;
    assign press_down = down_lvl & ~down_btn_q;

    // History resets to all-ones: a button held through reset must be
    // released before it can register a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_btn_q  <= '1;
            up_btn_q   <= '1;
            down_btn_q <= '1;
        end else begin
            car_btn_q  <= btn_car;
            up_btn_q   <= up_lvl;
            down_btn_q <= down_lvl;
        end
    end

    // Hall calls are only served when the car will leave in their direction;
    // the end floors have only one useful direction so they always serve.
    assign serve    = door_open ? (BOT_BIT << current_floor) : '0;
    assign clr_car  = serve;
    assign clr_up   = serve & ((last_dir_q != DIR_DOWN) ? '1 : BOT_BIT);
    assign clr_down = serve & ((last_dir_q != DIR_UP)   ? '1 : TOP_BIT);

    assign any_pending = |{lamp_car, lamp_up, lamp_down};
    // Only clearing something actually pending counts as service progress.
    assign any_clear   = |{clr_car & lamp_car, clr_up & lamp_up, clr_down & lamp_down};

    always_comb begin
        last_dir_d = last_dir_q;
        if (moving_up) begin
            last_dir_d = DIR_UP;
        end else if (moving_down) begin
            last_dir_d = DIR_DOWN;
        end else if (!any_pending) begin
            last_dir_d = DIR_IDLE;
        end
    end

    // A clear in the same cycle as expiry takes precedence: progress was made,
    // so no resend is due.
    assign resend = any_pending && !any_clear && (timer_q == TIMER_LAST);

    always_comb begin
        timer_d = timer_q;
        cnt_d   = cnt_q;
        if (!any_pending || any_clear) begin
            timer_d = '0;
            cnt_d   = '0;
        end else if (resend) begin
            timer_d = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dir_q <= DIR_IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
        end else begin
            last_dir_q <= last_dir_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stuck = (cnt_q == CNT_MAX);

    request_latch #(.NUM_FLOORS(NUM_FLOORS)) u_car_latch (
        .clk     (clk),
        .reset   (reset),
        .press   (press_car),
        .clear   (clr_car),
        .resend  (resend),
        .pending (lamp_car),
        .pulse   (inside_request)
    );

    request_latch #(.NUM_FLOORS(NUM_FLOORS)) u_up_latch (
        .clk     (clk),
        .reset   (reset),
        .press   (press_up),
        .clear   (clr_up),
        .resend  (resend),
        .pending (lamp_up),
        .pulse   (call_up)
    );

    request_latch #(.NUM_FLOORS(NUM_FLOORS)) u_down_latch (
        .clk     (clk),
        .reset   (reset),
        .press   (press_down),
        .clear   (clr_down),
        .resend  (resend),
        .pending (lamp_down),
        .pulse   (call_down)
    );

endmodule

// File: doc/elevator_request_panel.md
Name: elevator_request_panel

Overview:
- Front-end for elevator_controller. Takes raw car and hall button levels plus controller status (current_floor, moving_up, moving_down, door_open).
- Produces the one-cycle request pulses elevator_controller consumes on inside_request/call_up/call_down, and the held lamp states.
- Latches each press until the floor is served, re-issues unserved requests periodically, and flags stalled service.

Parameters:
- NUM_FLOORS, 4, number of floors (bit i = floor i).
- FLOOR_W, 2, width of current_floor.
- RESEND_CYCLES, 64, idle cycles without service before all pending requests are re-pulsed.
- MAX_RESEND, 4, re-pulse rounds without service before stuck asserts.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- btn_car  in  NUM_FLOORS  in-car buttons, level, pre-synchronised.
- btn_up  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored.
- btn_down  in  NUM_FLOORS  hall down buttons; bit 0 ignored.
- current_floor  in  FLOOR_W  from controller.
- moving_up  in  1  from controller.
- moving_down  in  1  from controller.
- door_open  in  1  from controller.
- inside_request  out  NUM_FLOORS  one-cycle request pulses to controller.
- call_up  out  NUM_FLOORS  one-cycle pulses.
- call_down  out  NUM_FLOORS  one-cycle pulses.
- lamp_car  out  NUM_FLOORS  pending car requests (held).
- lamp_up  out  NUM_FLOORS  pending up calls (held).
- lamp_down  out  NUM_FLOORS  pending down calls (held).
- stuck  out  1  service stall flag.

Behaviour:
- Reset: all outputs 0; pending latches, resend timer and resend counter cleared; last_dir=IDLE; button history regs set to all-ones, so a button held through reset must be released before it counts. Reset mid-operation drops all pending requests without emitting pulses.
- Press detect: press = btn & ~btn_q; btn_q <= btn every cycle. Invalid bits (btn_up[top], btn_down[0]) are forced to 0 before detection.
- last_dir register: UP when moving_up, DOWN when moving_down, otherwise holds. Becomes IDLE when all pending bits are 0 and the car is not moving.
- Service condition at floor f = current_floor with door_open=1:
  - car[f] is served.
  - up[f] is served if last_dir!=DOWN or f==0.
  - down[f] is served if last_dir!=UP or f==top.
- Registered outputs, latency 1: a press detected at edge N sets the lamp bit and a one-cycle pulse bit, both visible after edge N.
  - A press on an already-pending bit: no pulse, no change.
  - A press on a bit being served that same cycle: ignored (service wins, no latch, no pulse).
  - A served bit's lamp clears at the same edge.
- Pulses are exactly one cycle wide. Pulses never assert for non-pending bits.
- Resend timer:
  - Counts while any lamp is set.
  - Resets to 0 on any clear (service progress) or when nothing is pending.
  - On reaching RESEND_CYCLES-1: all currently pending bits pulse for one cycle, timer returns to 0, resend counter increments (saturating at MAX_RESEND).
  - A new press does not reset the timer.
- stuck: asserts when resend counter == MAX_RESEND. Both stuck and counter clear on any service clear or when nothing is pending.
- Simultaneous presses on several floors or types: all latch and pulse in the same cycle.

Decomposition:
- elevator_pkg holds: NUM_FLOORS and FLOOR_W defaults; direction encoding DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
- Sub-module request_latch (one per request type, instantiated 3x), parameter NUM_FLOORS:
  - inputs: press vector, clear vector, resend strobe.
  - outputs: pending vector, pulse vector.
- Top level owns edge detect, last_dir, service decode, resend timer and stuck flag.

Test Plan:
- Reset release with btn_car[2] held high -> no pulse, lamp_car=0; release then press -> inside_request=4'b0100 for exactly 1 cycle, lamp_car[2]=1.
- lamp_car[2]=1, current_floor=2, door_open=1 -> lamp_car[2] clears at that edge; a press of btn_car[2] during the open door -> no latch, no pulse.
- last_dir=UP, lamp_up[1]=lamp_down[1]=1, door_open at floor 1 -> lamp_up[1] clears, lamp_down[1] stays 1; btn_up[3] press -> no pulse.
- Same-cycle presses btn_car[1], btn_up[2], btn_down[3] -> inside_request=0010, call_up=0100, call_down=1000, all in one cycle.
- RESEND_CYCLES=8, lamp_car[3] pending, no service -> inside_request[3] re-pulses every 8 cycles; stuck=1 after the 4th resend; service at floor 3 -> stuck=0 and lamp cleared.
- Reset asserted with 3 lamps set -> all lamps and pulses 0 the next cycle; no re-pulse after reset.
